// File: rtl/fns_enc_3_2_seq.sv
// Sequential Fibonacci-numeral-system encoder: greedy MSB-first subtraction of the
// weights {1,1,FNS03,FNS04,FNS05}, one code bit per cycle, valid/ready on both sides.
module fns_enc_3_2_seq #(
  parameter int CODE_W = 5,
  parameter int DATA_W = 4,
  parameter int WGT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  input  logic [CODE_W-1:0] en_flag,
  input  logic [WGT_W-1:0]  FNS03,
  input  logic [WGT_W-1:0]  FNS04,
  input  logic [WGT_W-1:0]  FNS05,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              err
);

  localparam int CMP_W = (DATA_W > WGT_W) ? DATA_W : WGT_W;
  localparam int IDX_W = $clog2(CODE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CMP_W-1:0]    rem_q, rem_d;
  logic [CODE_W-1:0]   en_q, en_d;
  logic [WGT_W-1:0]    w3_q, w3_d, w4_q, w4_d, w5_q, w5_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   codeout_q, codeout_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CMP_W-1:0]    w_ext_s;

  // Bits 0 and 1 always carry weight one; the upper three come from the latched weights.
  function automatic logic [WGT_W-1:0] weight_of(
    input logic [IDX_W-1:0] idx,
    input logic [WGT_W-1:0] w3,
    input logic [WGT_W-1:0] w4,
    input logic [WGT_W-1:0] w5
  );
    logic [WGT_W-1:0] w;
    case (idx)
      IDX_W'(0): w = WGT_W'(1);
      IDX_W'(1): w = WGT_W'(1);
      IDX_W'(2): w = w3;
      IDX_W'(3): w = w4;
      IDX_W'(4): w = w5;
      default:   w = '0;
    endcase
    return w;
  endfunction

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign codeout   = codeout_q;
  assign err       = err_q;

  // Next-state and datapath: accept, one greedy step per CALC cycle, hold until drained.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    en_d        = en_q;
    w3_d        = w3_q;
    w4_d        = w4_q;
    w5_d        = w5_q;
    idx_d       = idx_q;
    code_d      = code_q;
    codeout_d   = codeout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    w_ext_s     = CMP_W'(weight_of(idx_q, w3_q, w4_q, w5_q));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d      = CMP_W'(datain);
          en_d       = en_flag;
          w3_d       = FNS03;
          w4_d       = FNS04;
          w5_d       = FNS05;
          idx_d      = IDX_W'(CODE_W - 1);
          code_d     = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CALC: begin
        // A zero weight never claims a bit, and rem >= w guards against underflow.
        if (en_q[idx_q] && (w_ext_s != '0) && (rem_q >= w_ext_s)) begin
          code_d = code_q | (CODE_W'(1) << idx_q);
          rem_d  = rem_q - w_ext_s;
        end else begin
          code_d = code_q;
        end
        if (idx_q == IDX_W'(0)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          codeout_d   = code_d;
          err_d       = (rem_d != '0);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      en_q        <= '0;
      w3_q        <= '0;
      w4_q        <= '0;
      w5_q        <= '0;
      idx_q       <= '0;
      code_q      <= '0;
      codeout_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      en_q        <= en_d;
      w3_q        <= w3_d;
      w4_q        <= w4_d;
      w5_q        <= w5_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      codeout_q   <= codeout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fns_enc_3_2_seq.sv
// Bench for fns_enc_3_2_seq: a cycle-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized transactions.
module tb_fns_enc_3_2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] datain = 4'd0;
  logic [4:0] en_flag = 5'd0;
  logic [3:0] fns03 = 4'd0, fns04 = 4'd0, fns05 = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] codeout;
  logic       err;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  fns_enc_3_2_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .en_flag(en_flag), .FNS03(fns03), .FNS04(fns04), .FNS05(fns05),
    .out_valid(out_valid), .out_ready(out_ready), .codeout(codeout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Greedy FNS encoding from the plain rules: returns {err, code}.
  function automatic logic [5:0] model_enc(input logic [3:0] d, input logic [4:0] en,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c);
    int w[5];
    int r;
    logic [4:0] code;
    w = '{1, 1, int'(a), int'(b), int'(c)};
    r = int'(d);
    code = 5'd0;
    for (int i = 4; i >= 0; i--) begin
      if (en[i] && w[i] != 0 && r >= w[i]) begin
        code[i] = 1'b1;
        r = r - w[i];
      end
    end
    return {r != 0, code};
  endfunction

  // Cycle model: 0 idle, 1 computing (five cycles), 2 presenting result.
  int         m_phase;
  int         m_cnt;
  logic [5:0] m_pend;
  logic [4:0] m_code;
  logic       m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_cnt <= 0; m_pend <= 6'd0; m_code <= 5'd0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend  <= model_enc(datain, en_flag, fns03, fns04, fns05);
          m_phase <= 1;
          m_cnt   <= 5;
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_phase <= 2;
            m_code  <= m_pend[4:0];
            m_err   <= m_pend[5];
          end
        end
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("codeout", codeout, m_code);
      if (out_valid) chk("err", err, m_err);
    end
  end

  task automatic send(input logic [3:0] d, input logic [4:0] en,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    datain = d; en_flag = en; fns03 = a; fns04 = b; fns05 = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble everything after accept: the encoder must use what it latched.
    datain = 4'($urandom); en_flag = 5'($urandom);
    fns03 = 4'($urandom); fns04 = 4'($urandom); fns05 = 4'($urandom);
  endtask

  task automatic finish_txn(input int hold, input bit lit,
                            input logic [4:0] exp_code, input logic exp_err);
    int n;
    logic [4:0] held;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5);
    if (lit) begin
      chk("lit_codeout", codeout, exp_code);
      chk("lit_err", err, exp_err);
    end
    held = codeout;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_code", codeout, held);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_busy", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [5:0] r;
    // Pin the model to hand-computed encodings.
    r = model_enc(4'd12, 5'b11111, 4'd2, 4'd3, 4'd5); chk("model_12", r, 6'b0_11111);
    r = model_enc(4'd7,  5'b11111, 4'd2, 4'd3, 4'd5); chk("model_7", r, 6'b0_10100);
    r = model_enc(4'd13, 5'b11111, 4'd2, 4'd3, 4'd5); chk("model_13", r, 6'b1_11111);
    r = model_enc(4'd1,  5'b11011, 4'd0, 4'd3, 4'd5); chk("model_1", r, 6'b0_00010);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_codeout", codeout, 5'd0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    send(4'd12, 5'b11111, 4'd2, 4'd3, 4'd5); finish_txn(0, 1'b1, 5'b11111, 1'b0);
    send(4'd7,  5'b11111, 4'd2, 4'd3, 4'd5); fns05 = 4'd9;
    finish_txn(0, 1'b1, 5'b10100, 1'b0);
    send(4'd7,  5'b01111, 4'd2, 4'd3, 4'd5); finish_txn(0, 1'b1, 5'b01111, 1'b0);
    send(4'd13, 5'b11111, 4'd2, 4'd3, 4'd5); finish_txn(0, 1'b1, 5'b11111, 1'b1);
    send(4'd1,  5'b11011, 4'd0, 4'd3, 4'd5); finish_txn(0, 1'b1, 5'b00010, 1'b0);
    send(4'd12, 5'b11111, 4'd2, 4'd3, 4'd5); finish_txn(3, 1'b1, 5'b11111, 1'b0);

    // Reset during the third computing cycle.
    send(4'd7, 5'b11111, 4'd2, 4'd3, 4'd5);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_codeout", codeout, 5'd0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'd5, 5'b11111, 4'd2, 4'd3, 4'd5); finish_txn(0, 1'b1, 5'b10000, 1'b0);

    for (int t = 0; t < 60; t++) begin
      send(4'($urandom), 5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      finish_txn($urandom_range(0, 2), 1'b0, 5'd0, 1'b0);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
